// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: drives per-stage hold/flush, exception redirect,
// multi-cycle divide stall sequencing and a saturating stall-cycle counter.
module pipeline_ctrl #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_use,
  input  logic        div_start,
  input  logic        mem_req,
  input  logic        mem_ack,
  input  logic        exc_valid,
  input  logic [31:0] exc_vector,
  output logic        hold_pc,
  output logic        hold_ifid,
  output logic        hold_idex,
  output logic        hold_exmem,
  output logic        hold_memwb,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        flush_exmem,
  output logic        flush_memwb,
  output logic        pc_redirect,
  output logic [31:0] redirect_addr,
  output logic        div_busy,
  output logic        div_done,
  output logic [15:0] stall_count
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned SC_W   = 16;
  localparam int unsigned ADDR_W = 32;

  // The divide cycle itself counts as the first stall cycle, and the cycle
  // with div_cnt==0 is the last, so the counter loads DIV_CYCLES-2.
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 32'd2);
  localparam logic [SC_W-1:0]  SC_MAX   = '1;

  if (DIV_CYCLES < 2 || DIV_CYCLES > 65535) begin : g_bad_div_cycles
    $error("pipeline_ctrl: DIV_CYCLES out of range 2..65535");
  end

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_DIV = 1'b1
  } state_t;

  state_t            state_q, state_d;
  state_t            state_cur;
  logic [CNT_W-1:0]  div_cnt_q, div_cnt_d;
  logic [SC_W-1:0]   stall_count_q, stall_count_d;

  logic              mem_wait;

  // Reset forces the outputs to look like RUN in the same cycle.
  always_comb begin
    state_cur = state_q;
    if (rst) begin
      state_cur = ST_RUN;
    end
  end

  // Divide status, independent of which hazard owns hold/flush.
  always_comb begin
    div_busy = 1'b0;
    div_done = 1'b0;
    if (state_cur == ST_DIV) begin
      div_busy = 1'b1;
      div_done = (div_cnt_q == '0);
    end else if (div_start) begin
      div_busy = 1'b1;
    end
  end

  assign mem_wait = mem_req && !mem_ack;

  // Prioritised hold/flush/redirect: exception > memory wait > divide > load-use.
  always_comb begin
    hold_pc       = 1'b0;
    hold_ifid     = 1'b0;
    hold_idex     = 1'b0;
    hold_exmem    = 1'b0;
    hold_memwb    = 1'b0;
    flush_ifid    = 1'b0;
    flush_idex    = 1'b0;
    flush_exmem   = 1'b0;
    flush_memwb   = 1'b0;
    pc_redirect   = 1'b0;
    redirect_addr = '0;
    if (exc_valid) begin
      flush_ifid    = 1'b1;
      flush_idex    = 1'b1;
      flush_exmem   = 1'b1;
      flush_memwb   = 1'b1;
      pc_redirect   = 1'b1;
      redirect_addr = ADDR_W'(exc_vector);
    end else if (mem_wait) begin
      hold_pc     = 1'b1;
      hold_ifid   = 1'b1;
      hold_idex   = 1'b1;
      hold_exmem  = 1'b1;
      flush_memwb = 1'b1;
    end else if (div_busy) begin
      hold_pc     = 1'b1;
      hold_ifid   = 1'b1;
      hold_idex   = 1'b1;
      flush_exmem = 1'b1;
    end else if (load_use) begin
      hold_pc    = 1'b1;
      hold_ifid  = 1'b1;
      flush_idex = 1'b1;
    end
  end

  // Divide FSM next state; keeps running underneath a memory wait.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    if (rst) begin
      state_d   = ST_RUN;
      div_cnt_d = '0;
    end else if (exc_valid) begin
      state_d   = ST_RUN;
      div_cnt_d = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (div_start) begin
            state_d   = ST_DIV;
            div_cnt_d = DIV_LOAD;
          end
        end
        ST_DIV: begin
          if (div_cnt_q == '0) begin
            state_d = ST_RUN;
          end else begin
            div_cnt_d = div_cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d   = ST_RUN;
          div_cnt_d = '0;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_comb begin
    stall_count_d = stall_count_q;
    if (rst) begin
      stall_count_d = '0;
    end else if (hold_pc && (stall_count_q != SC_MAX)) begin
      stall_count_d = stall_count_q + SC_W'(1);
    end
  end

  // State, divide counter and performance counter registers.
  always_ff @(posedge clk) begin
    state_q       <= state_d;
    div_cnt_q     <= div_cnt_d;
    stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: priority table under reset, then
// multi-cycle divide / memory-wait / exception / saturation sequences.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst, load_use, div_start, mem_req, mem_ack, exc_valid;
  logic [31:0] exc_vector;

  logic        hold_pc, hold_ifid, hold_idex, hold_exmem, hold_memwb;
  logic        flush_ifid, flush_idex, flush_exmem, flush_memwb;
  logic        pc_redirect, div_busy, div_done;
  logic [31:0] redirect_addr;
  logic [15:0] stall_count;

  logic        h2_pc, h2_ifid, h2_idex, h2_exmem, h2_memwb;
  logic        f2_ifid, f2_idex, f2_exmem, f2_memwb;
  logic        redir2, busy2, done2;
  logic [31:0] addr2;
  logic [15:0] sc2;

  always #5 clk = ~clk;

  pipeline_ctrl #(.DIV_CYCLES(32)) u_dut (
    .clk(clk), .rst(rst), .load_use(load_use), .div_start(div_start),
    .mem_req(mem_req), .mem_ack(mem_ack), .exc_valid(exc_valid), .exc_vector(exc_vector),
    .hold_pc(hold_pc), .hold_ifid(hold_ifid), .hold_idex(hold_idex),
    .hold_exmem(hold_exmem), .hold_memwb(hold_memwb),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
    .flush_memwb(flush_memwb), .pc_redirect(pc_redirect), .redirect_addr(redirect_addr),
    .div_busy(div_busy), .div_done(div_done), .stall_count(stall_count)
  );

  // Minimum-length divide variant sharing the same stimulus.
  pipeline_ctrl #(.DIV_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .load_use(load_use), .div_start(div_start),
    .mem_req(mem_req), .mem_ack(mem_ack), .exc_valid(exc_valid), .exc_vector(exc_vector),
    .hold_pc(h2_pc), .hold_ifid(h2_ifid), .hold_idex(h2_idex),
    .hold_exmem(h2_exmem), .hold_memwb(h2_memwb),
    .flush_ifid(f2_ifid), .flush_idex(f2_idex), .flush_exmem(f2_exmem),
    .flush_memwb(f2_memwb), .pc_redirect(redir2), .redirect_addr(addr2),
    .div_busy(busy2), .div_done(done2), .stall_count(sc2)
  );

  // Output vector: {hold pc,ifid,idex,exmem,memwb, flush ifid,idex,exmem,memwb, redirect, busy, done}
  localparam logic [11:0] P_IDLE = 12'b00000_0000_000;
  localparam logic [11:0] P_EXC  = 12'b00000_1111_100;
  localparam logic [11:0] P_MEM  = 12'b11110_0001_000;
  localparam logic [11:0] P_DIV  = 12'b11100_0010_000;
  localparam logic [11:0] P_LU   = 12'b11000_0100_000;
  localparam logic [11:0] B_BUSY = 12'b00000_0000_010;
  localparam logic [11:0] B_DONE = 12'b00000_0000_001;

  typedef struct {
    logic        r, lu, ds, mr, ma, ev;
    logic [31:0] vec;
    logic [11:0] exp_o;
    logic [31:0] exp_a;
  } vec_t;

  typedef struct packed {
    logic [11:0] o;
    logic [31:0] a;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[14];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [11:0] outs();
    return {hold_pc, hold_ifid, hold_idex, hold_exmem, hold_memwb,
            flush_ifid, flush_idex, flush_exmem, flush_memwb,
            pc_redirect, div_busy, div_done};
  endfunction

  // Drive one cycle at negedge, queue the expectation, sample 1 ns later.
  task automatic step(input string nm, input int idx,
                      input logic r, input logic lu, input logic ds,
                      input logic mr, input logic ma, input logic ev,
                      input logic [31:0] vec, input logic [11:0] eo,
                      input logic [31:0] ea);
    exp_t e;
    logic [11:0] got;
    @(negedge clk);
    rst = r; load_use = lu; div_start = ds; mem_req = mr; mem_ack = ma;
    exc_valid = ev; exc_vector = vec;
    sb.push_back('{o: eo, a: ea});
    #1;
    got = outs();
    e = sb.pop_front();
    n_checks++;
    if (got !== e.o || redirect_addr !== e.a) begin
      n_fail++;
      $display("FAIL %s[%0d]: got outs=%b addr=%h, expected outs=%b addr=%h",
               nm, idx, got, redirect_addr, e.o, e.a);
    end
  endtask

  task automatic chk_sc(input string nm, input logic [15:0] exp_sc);
    n_checks++;
    if (stall_count !== exp_sc) begin
      n_fail++;
      $display("FAIL %s: stall_count got %0d, expected %0d", nm, stall_count, exp_sc);
    end
  endtask

  task automatic chk_div2(input string nm, input int idx, input logic eb, input logic ed);
    n_checks++;
    if (busy2 !== eb || done2 !== ed) begin
      n_fail++;
      $display("FAIL %s[%0d]: div2 busy/done got %b%b, expected %b%b",
               nm, idx, busy2, done2, eb, ed);
    end
  endtask

  task automatic do_reset();
    step("reset", 0, 1, 0, 0, 0, 0, 0, 32'h0, P_IDLE, 32'h0);
  endtask

  initial begin
    rst = 1'b1; load_use = 1'b0; div_start = 1'b0; mem_req = 1'b0;
    mem_ack = 1'b0; exc_valid = 1'b0; exc_vector = 32'h0;

    //            r  lu ds mr ma ev  vec            expected outs      expected addr
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 32'h0000_0000, P_IDLE,          32'h0000_0000};
    tbl[1]  = '{1, 0, 0, 0, 0, 0, 32'hBFC0_0380, P_IDLE,          32'h0000_0000};
    tbl[2]  = '{1, 1, 0, 0, 0, 0, 32'h0000_0000, P_LU,            32'h0000_0000};
    tbl[3]  = '{1, 0, 1, 0, 0, 0, 32'h0000_0000, P_DIV | B_BUSY,  32'h0000_0000};
    tbl[4]  = '{1, 0, 0, 1, 0, 0, 32'h0000_0000, P_MEM,           32'h0000_0000};
    tbl[5]  = '{1, 0, 0, 1, 1, 0, 32'h0000_0000, P_IDLE,          32'h0000_0000};
    tbl[6]  = '{1, 0, 0, 0, 0, 1, 32'h8000_0180, P_EXC,           32'h8000_0180};
    tbl[7]  = '{1, 1, 1, 0, 0, 0, 32'h0000_0000, P_DIV | B_BUSY,  32'h0000_0000};
    tbl[8]  = '{1, 1, 0, 1, 0, 0, 32'h0000_0000, P_MEM,           32'h0000_0000};
    tbl[9]  = '{1, 0, 1, 1, 0, 0, 32'h0000_0000, P_MEM | B_BUSY,  32'h0000_0000};
    tbl[10] = '{1, 1, 0, 1, 0, 1, 32'h1234_5678, P_EXC,           32'h1234_5678};
    tbl[11] = '{1, 0, 0, 0, 1, 0, 32'h0000_0000, P_IDLE,          32'h0000_0000};
    tbl[12] = '{1, 1, 0, 1, 1, 0, 32'h0000_0000, P_LU,            32'h0000_0000};
    tbl[13] = '{1, 0, 0, 1, 1, 1, 32'h0000_0004, P_EXC,           32'h0000_0004};

    // Priority table, applied while reset holds the FSM in RUN.
    for (int i = 0; i < 14; i++) begin
      step("table", i, tbl[i].r, tbl[i].lu, tbl[i].ds, tbl[i].mr, tbl[i].ma,
           tbl[i].ev, tbl[i].vec, tbl[i].exp_o, tbl[i].exp_a);
    end

    // Reset then idle: everything quiet, counter cleared.
    step("idle", 0, 0, 0, 0, 0, 0, 0, 32'h0, P_IDLE, 32'h0);
    chk_sc("idle_sc", 16'd0);

    // Full 32-cycle divide; a second div_start mid-divide is ignored.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      step("div32", i, 0, 0, (i == 0 || i == 5), 0, 0, 0, 32'h0,
           P_DIV | B_BUSY | ((i == 31) ? B_DONE : 12'h0), 32'h0);
    end
    step("div32_end", 32, 0, 0, 0, 0, 0, 0, 32'h0, P_IDLE, 32'h0);
    chk_sc("div32_sc", 16'd32);

    // Memory wait for 3 cycles, released by mem_ack.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step("memwait", i, 0, 0, 0, 1, 0, 0, 32'h0, P_MEM, 32'h0);
    end
    step("memack", 3, 0, 0, 0, 1, 1, 0, 32'h0, P_IDLE, 32'h0);
    chk_sc("mem_sc", 16'd3);

    // Load-use loses to divide, then shows once the divide ends.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      step("lu_div", i, 0, 1, (i == 0), 0, 0, 0, 32'h0,
           P_DIV | B_BUSY | ((i == 31) ? B_DONE : 12'h0), 32'h0);
    end
    step("lu_alone", 32, 0, 1, 0, 0, 0, 0, 32'h0, P_LU, 32'h0);

    // Exception on divide cycle 10 aborts the divide.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step("exc_div", i, 0, 0, (i == 0), 0, 0, 0, 32'h0, P_DIV | B_BUSY, 32'h0);
    end
    step("exc_div", 9, 0, 0, 0, 0, 0, 1, 32'hBFC0_0380, P_EXC | B_BUSY, 32'hBFC0_0380);
    step("exc_after", 10, 0, 0, 0, 0, 0, 0, 32'h0, P_IDLE, 32'h0);
    chk_sc("exc_sc", 16'd9);

    // Divide keeps counting under a dominant memory wait.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      step("mem_div", i, 0, 0, (i == 0), 1, 0, 0, 32'h0,
           P_MEM | B_BUSY | ((i == 31) ? B_DONE : 12'h0), 32'h0);
    end
    step("mem_div_end", 32, 0, 0, 0, 1, 1, 0, 32'h0, P_IDLE, 32'h0);
    chk_sc("mem_div_sc", 16'd32);

    // Minimum-length divide: done pulses the cycle after div_start.
    do_reset();
    step("div2", 0, 0, 0, 1, 0, 0, 0, 32'h0, P_DIV | B_BUSY, 32'h0);
    chk_div2("div2", 0, 1'b1, 1'b0);
    step("div2", 1, 0, 0, 0, 0, 0, 0, 32'h0, P_DIV | B_BUSY, 32'h0);
    chk_div2("div2", 1, 1'b1, 1'b1);
    step("div2", 2, 0, 0, 0, 0, 0, 0, 32'h0, P_DIV | B_BUSY, 32'h0);
    chk_div2("div2", 2, 1'b0, 1'b0);

    // Reset mid-divide: RUN outputs during reset and afterwards.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step("rst_div", i, 0, 0, (i == 0), 0, 0, 0, 32'h0, P_DIV | B_BUSY, 32'h0);
    end
    step("rst_div", 5, 1, 0, 0, 0, 0, 0, 32'h0, P_IDLE, 32'h0);
    step("rst_div", 6, 0, 0, 0, 0, 0, 0, 32'h0, P_IDLE, 32'h0);
    chk_sc("rst_div_sc", 16'd0);

    // Long memory wait saturates the stall counter.
    do_reset();
    @(negedge clk);
    rst = 1'b0; mem_req = 1'b1; mem_ack = 1'b0;
    repeat (70000) @(negedge clk);
    step("sat", 0, 0, 0, 0, 1, 0, 0, 32'h0, P_MEM, 32'h0);
    chk_sc("sat_sc", 16'hFFFF);
    step("sat", 1, 0, 0, 0, 1, 0, 0, 32'h0, P_MEM, 32'h0);
    chk_sc("sat_sc_hold", 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
